// File: rtl/bus_cycle_ctrl_pkg.sv
// Shared definitions for the bus cycle controller: state encoding,
// default timing parameters and counter sizing.
package bus_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_LOW,
        ST_SETUP,
        ST_ACTIVE,
        ST_STRETCH,
        ST_HOLD
    } state_t;

    localparam int unsigned DEF_DIV        = 8;
    localparam int unsigned DEF_SETUP_CLKS = 2;
    localparam int unsigned DEF_WAIT_CLKS  = 4;

    // Width needed to hold the largest phase reload value (max(div, wait_clks) - 1).
    function automatic int unsigned cnt_width(input int unsigned div, input int unsigned wait_clks);
        int unsigned m;
        m = (div > wait_clks) ? div : wait_clks;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bus_cycle_ctrl_phase_counter.sv
// Loadable down-counter timing each bus phase; tc flags the last clock of a phase.
module phase_counter #(
    parameter int unsigned    W         = 3,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= RESET_VAL;
        else if (load)
            cnt <= load_val;
        else if (en)
            cnt <= cnt - W'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/bus_cycle_ctrl.sv
// CPU bus clock (phi0) generator with qualified enable, read/write strobes,
// slow-device stretching and halt.
module bus_cycle_ctrl
    import bus_cycle_ctrl_pkg::*;
#(
    parameter int unsigned DIV        = DEF_DIV,
    parameter int unsigned SETUP_CLKS = DEF_SETUP_CLKS,
    parameter int unsigned WAIT_CLKS  = DEF_WAIT_CLKS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rw,
    input  logic slow,
    input  logic halt,
    output logic phi0,
    output logic enable,
    output logic oe_n,
    output logic we_n,
    output logic cycle_end
);

    localparam int unsigned    CW       = cnt_width(DIV, WAIT_CLKS);
    localparam int unsigned    ACT_CLKS = DIV - SETUP_CLKS - 1;
    localparam logic [CW-1:0]  LD_LOW   = CW'(DIV - 1);
    localparam logic [CW-1:0]  LD_SETUP = CW'(SETUP_CLKS - 1);
    localparam logic [CW-1:0]  LD_ACT   = CW'(ACT_CLKS - 1);
    localparam logic [CW-1:0]  LD_WAIT  = CW'(WAIT_CLKS - 1);

    state_t        state, nxt;
    logic [CW-1:0] cnt, ld_val;
    logic          ld, tc;
    logic          rw_l, slow_l;
    logic          first_act, slow_eff;
    logic          phi0_d, en_d, rw_d, oe_d, we_d, ce_d, slow_d;

    phase_counter #(
        .W         (CW),
        .RESET_VAL (LD_LOW)
    ) u_phase_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (ld),
        .load_val (ld_val),
        .en       (!tc),
        .cnt      (cnt),
        .tc       (tc)
    );

    // slow is honoured only while still in the first ACTIVE clock; later changes are ignored.
    assign first_act = (state == ST_ACTIVE) && (cnt == LD_ACT);
    assign slow_eff  = first_act ? slow : slow_l;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_LOW;
        else
            state <= nxt;
    end

    always_comb begin
        nxt    = state;
        ld     = 1'b0;
        ld_val = '0;
        case (state)
            ST_LOW: begin
                if (tc && !halt) begin
                    nxt    = ST_SETUP;
                    ld     = 1'b1;
                    ld_val = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tc) begin
                    nxt    = ST_ACTIVE;
                    ld     = 1'b1;
                    ld_val = LD_ACT;
                end
            end
            ST_ACTIVE: begin
                if (tc) begin
                    ld = 1'b1;
                    if (slow_eff && (WAIT_CLKS != 0)) begin
                        nxt    = ST_STRETCH;
                        ld_val = LD_WAIT;
                    end else begin
                        nxt = ST_HOLD;
                    end
                end
            end
            ST_STRETCH: begin
                if (tc) begin
                    nxt = ST_HOLD;
                    ld  = 1'b1;
                end
            end
            ST_HOLD: begin
                nxt    = ST_LOW;
                ld     = 1'b1;
                ld_val = LD_LOW;
            end
            default: begin
                nxt    = ST_LOW;
                ld     = 1'b1;
                ld_val = LD_LOW;
            end
        endcase
    end

    // Outputs decode the next state so they are registered yet line up with the state.
    always_comb begin
        phi0_d = (nxt != ST_LOW);
        en_d   = (nxt == ST_ACTIVE) || (nxt == ST_STRETCH);
        rw_d   = ((nxt == ST_SETUP) && (state != ST_SETUP)) ? rw : rw_l;
        oe_d   = !(en_d && rw_d);
        we_d   = !(en_d && !rw_d);
        ce_d   = (state == ST_LOW) && (cnt == CW'(1));
        slow_d = slow_eff;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phi0      <= 1'b0;
            enable    <= 1'b0;
            oe_n      <= 1'b1;
            we_n      <= 1'b1;
            cycle_end <= 1'b0;
            rw_l      <= 1'b1;
            slow_l    <= 1'b0;
        end else begin
            phi0      <= phi0_d;
            enable    <= en_d;
            oe_n      <= oe_d;
            we_n      <= we_d;
            cycle_end <= ce_d;
            rw_l      <= rw_d;
            slow_l    <= slow_d;
        end
    end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl at default timing (DIV=8, SETUP_CLKS=2, WAIT_CLKS=4).
module tb_bus_cycle_ctrl;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rw = 1'b1;
    logic slow = 1'b0;
    logic halt = 1'b0;
    logic phi0, enable, oe_n, we_n, cycle_end;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bus_cycle_ctrl #(
        .DIV        (8),
        .SETUP_CLKS (2),
        .WAIT_CLKS  (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rw        (rw),
        .slow      (slow),
        .halt      (halt),
        .phi0      (phi0),
        .enable    (enable),
        .oe_n      (oe_n),
        .we_n      (we_n),
        .cycle_end (cycle_end)
    );

    typedef struct {
        int   k;
        logic rw, slow, halt;
        logic phi0, en, oe_n, we_n, ce;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int k, input logic r, input logic s, input logic h,
                                input logic p, input logic e, input logic o, input logic w,
                                input logic c);
        vec_t v;
        v.k = k; v.rw = r; v.slow = s; v.halt = h;
        v.phi0 = p; v.en = e; v.oe_n = o; v.we_n = w; v.ce = c;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // k counts rising edges after reset release; inputs of a row are driven before advancing to it.
    task automatic run_table(input string tag);
        int cur;
        cur = 0;
        foreach (tbl[i]) begin
            rw   = tbl[i].rw;
            slow = tbl[i].slow;
            halt = tbl[i].halt;
            tick(tbl[i].k - cur);
            cur = tbl[i].k;
            chk($sformatf("%s k=%0d phi0", tag, cur),      phi0,      tbl[i].phi0);
            chk($sformatf("%s k=%0d enable", tag, cur),    enable,    tbl[i].en);
            chk($sformatf("%s k=%0d oe_n", tag, cur),      oe_n,      tbl[i].oe_n);
            chk($sformatf("%s k=%0d we_n", tag, cur),      we_n,      tbl[i].we_n);
            chk($sformatf("%s k=%0d cycle_end", tag, cur), cycle_end, tbl[i].ce);
        end
    endtask

    // Starts on the first phi0-high clock, ends on the first phi0-low clock.
    task automatic measure_high(input int slow_idx, input bit toggle_rw,
                                output int ph, output int en_c, output int oe_lo, output int we_lo);
        int i;
        ph = 0; en_c = 0; oe_lo = 0; we_lo = 0;
        i = 0;
        while (phi0 && i < 40) begin
            ph    += 1;
            en_c  += int'(enable);
            oe_lo += int'(!oe_n);
            we_lo += int'(!we_n);
            slow = (i == slow_idx);
            if (toggle_rw && i >= 2)
                rw = ~rw;
            tick(1);
            i++;
        end
        slow = 1'b0;
    endtask

    task automatic measure_low(output int lo, output int ce_c);
        int i;
        lo = 0; ce_c = 0;
        i = 0;
        while (!phi0 && i < 60) begin
            lo   += 1;
            ce_c += int'(cycle_end);
            tick(1);
            i++;
        end
    endtask

    initial begin
        int ph, en_c, oe_lo, we_lo, lo, ce_c;

        // Inputs held at rw=1/slow=0 except where a row probes an ignored input.
        add( 1, 1, 0, 0,  0, 0, 1, 1, 0);
        add( 6, 1, 0, 1,  0, 0, 1, 1, 0);
        add( 7, 1, 0, 0,  0, 0, 1, 1, 1);
        add( 8, 1, 0, 0,  1, 0, 1, 1, 0);
        add( 9, 1, 0, 0,  1, 0, 1, 1, 0);
        add(10, 1, 0, 0,  1, 1, 0, 1, 0);
        add(11, 1, 0, 0,  1, 1, 0, 1, 0);
        add(12, 0, 1, 1,  1, 1, 0, 1, 0);
        add(14, 1, 0, 0,  1, 1, 0, 1, 0);
        add(15, 1, 0, 0,  1, 0, 1, 1, 0);
        add(16, 1, 0, 0,  0, 0, 1, 1, 0);
        add(22, 1, 0, 0,  0, 0, 1, 1, 0);
        add(23, 1, 0, 0,  0, 0, 1, 1, 1);
        add(24, 1, 0, 0,  1, 0, 1, 1, 0);
        add(26, 1, 0, 0,  1, 1, 0, 1, 0);
        add(30, 1, 0, 0,  1, 1, 0, 1, 0);
        add(31, 1, 0, 0,  1, 0, 1, 1, 0);
        add(32, 1, 0, 0,  0, 0, 1, 1, 0);

        #22;
        chk("reset phi0", phi0, 0);
        chk("reset enable", enable, 0);
        chk("reset oe_n", oe_n, 1);
        chk("reset we_n", we_n, 1);
        chk("reset cycle_end", cycle_end, 0);
        #6 reset_n = 1'b1;

        run_table("nominal");

        rw = 1'b0;
        measure_low(lo, ce_c);
        chk("pre-write low clocks", lo, 8);
        chk("pre-write cycle_end pulses", ce_c, 1);
        measure_high(-1, 1'b1, ph, en_c, oe_lo, we_lo);
        chk("write phi0 high", ph, 8);
        chk("write enable high", en_c, 5);
        chk("write oe_n low", oe_lo, 0);
        chk("write we_n low", we_lo, 5);

        rw = 1'b1;
        measure_low(lo, ce_c);
        chk("post-write low clocks", lo, 8);
        measure_high(2, 1'b0, ph, en_c, oe_lo, we_lo);
        chk("stretch phi0 high", ph, 12);
        chk("stretch enable high", en_c, 9);
        chk("stretch oe_n low", oe_lo, 9);
        chk("stretch we_n low", we_lo, 0);

        measure_low(lo, ce_c);
        chk("post-stretch low clocks", lo, 8);
        chk("post-stretch cycle_end pulses", ce_c, 1);
        measure_high(-1, 1'b0, ph, en_c, oe_lo, we_lo);
        chk("after-stretch phi0 high", ph, 8);
        chk("after-stretch enable high", en_c, 5);

        measure_low(lo, ce_c);
        measure_high(3, 1'b0, ph, en_c, oe_lo, we_lo);
        chk("late-slow phi0 high", ph, 8);
        chk("late-slow enable high", en_c, 5);

        halt = 1'b1;
        ph = 0; ce_c = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            ph   += int'(phi0);
            ce_c += int'(cycle_end);
        end
        chk("halt phi0 high clocks", ph, 0);
        chk("halt cycle_end pulses", ce_c, 1);
        halt = 1'b0;
        tick(1);
        chk("halt release phi0", phi0, 1);
        chk("halt release enable", enable, 0);

        tick(3);
        chk("pre-reset enable", enable, 1);
        chk("pre-reset oe_n", oe_n, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async reset phi0", phi0, 0);
        chk("async reset enable", enable, 0);
        chk("async reset oe_n", oe_n, 1);
        chk("async reset we_n", we_n, 1);
        tick(3);
        #2 reset_n = 1'b1;

        run_table("recovery");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
